counter_updown_mod: RTL and testbench

Parametrised successor to the 8-bit enable/clear binary counter. It is a WIDTH-bit synchronous counter with a programmable modulus, up/down direction, parallel load, and wrap or saturate mode. It provides a combinational terminal-count output so several instances can be cascaded into wider counters. Lab timer, divider and event-count datapaths instantiate it where the fixed 8-bit counter was used before.

---
 rtl/counter_updown_mod.sv | 91 +++++++++
 tb/tb_counter_updown_mod.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// counter_updown_mod: WIDTH-bit modulo counter with up/down stepping, parallel load,
// wrap or saturate handling at the end of range, and a cascadable terminal count.
module counter_updown_mod #(
    parameter int unsigned     WIDTH       = 8,
    parameter longint unsigned MODULUS     = 256,
    parameter longint unsigned RESET_VALUE = 0
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Enable,
    input  logic             Up,
    input  logic             Saturate,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_Value,
    output logic [WIDTH-1:0] Count_Contents,
    output logic             Terminal_Count,
    output logic             Wrap_Pulse,
    output logic             Overflow
);
    // MODULUS may equal 2^WIDTH, so the top value is formed in 64 bits before narrowing.
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_p0;
    logic             wrap_p0;
    logic             ovf_p0;

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             ovf_nxt;
    logic             at_max;
    logic             at_zero;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_CNT) ? MAX_CNT : v;
    endfunction

    assign at_max  = (count_p0 == MAX_CNT);
    assign at_zero = (count_p0 == '0);

    always_comb begin
        count_nxt = count_p0;
        wrap_nxt  = 1'b0;
        ovf_nxt   = ovf_p0;
        if (Load) begin
            count_nxt = clamp_load(Load_Value);
            ovf_nxt   = 1'b0;
        end else if (Enable) begin
            if (Up) begin
                if (!at_max) begin
                    count_nxt = count_p0 + ONE;
                end else if (Saturate) begin
                    ovf_nxt = 1'b1;
                end else begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_nxt = count_p0 - ONE;
                end else if (Saturate) begin
                    ovf_nxt = 1'b1;
                end else begin
                    count_nxt = MAX_CNT;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    // Stage p0: count and status registers
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            count_p0 <= RST_CNT;
            wrap_p0  <= 1'b0;
            ovf_p0   <= 1'b0;
        end else begin
            count_p0 <= count_nxt;
            wrap_p0  <= wrap_nxt;
            ovf_p0   <= ovf_nxt;
        end
    end

    // Terminal count ignores Saturate so a cascade sees the same carry in both modes.
    assign Terminal_Count = Enable & ~Load & ((Up & at_max) | (~Up & at_zero));
    assign Count_Contents = count_p0;
    assign Wrap_Pulse     = wrap_p0;
    assign Overflow       = ovf_p0;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: table vectors, directed corner sequences,
// a two-stage cascade and randomized stimulus against a behavioural model.
module tb_counter_updown_mod;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Group A: WIDTH 4, MODULUS 10, RESET_VALUE 3; group D shares A's inputs with MODULUS 2
    logic       a_clr, a_en, a_up, a_sat, a_load;
    logic [3:0] a_lv;
    logic [3:0] a_cnt, d_cnt;
    logic       a_tc, a_wrap, a_ovf, d_tc, d_wrap, d_ovf;

    // Group B: default WIDTH 8, MODULUS 256
    logic       b_clr, b_en, b_up, b_sat, b_load;
    logic [7:0] b_lv;
    logic [7:0] b_cnt;
    logic       b_tc, b_wrap, b_ovf;

    // Cascade: two WIDTH 4, MODULUS 16 stages
    logic       c_clr, c_en, c_up, c_zero;
    logic [3:0] c_lv0;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_tc, lo_wrap, lo_ovf, hi_tc, hi_wrap, hi_ovf;

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) u_a (
        .Clk(clk), .Clear(a_clr), .Enable(a_en), .Up(a_up), .Saturate(a_sat),
        .Load(a_load), .Load_Value(a_lv), .Count_Contents(a_cnt),
        .Terminal_Count(a_tc), .Wrap_Pulse(a_wrap), .Overflow(a_ovf));

    counter_updown_mod #(.WIDTH(4), .MODULUS(2), .RESET_VALUE(0)) u_d (
        .Clk(clk), .Clear(a_clr), .Enable(a_en), .Up(a_up), .Saturate(a_sat),
        .Load(a_load), .Load_Value(a_lv), .Count_Contents(d_cnt),
        .Terminal_Count(d_tc), .Wrap_Pulse(d_wrap), .Overflow(d_ovf));

    counter_updown_mod u_b (
        .Clk(clk), .Clear(b_clr), .Enable(b_en), .Up(b_up), .Saturate(b_sat),
        .Load(b_load), .Load_Value(b_lv), .Count_Contents(b_cnt),
        .Terminal_Count(b_tc), .Wrap_Pulse(b_wrap), .Overflow(b_ovf));

    counter_updown_mod #(.WIDTH(4), .MODULUS(16)) u_lo (
        .Clk(clk), .Clear(c_clr), .Enable(c_en), .Up(c_up), .Saturate(c_zero),
        .Load(c_zero), .Load_Value(c_lv0), .Count_Contents(lo_cnt),
        .Terminal_Count(lo_tc), .Wrap_Pulse(lo_wrap), .Overflow(lo_ovf));

    counter_updown_mod #(.WIDTH(4), .MODULUS(16)) u_hi (
        .Clk(clk), .Clear(c_clr), .Enable(lo_tc), .Up(c_up), .Saturate(c_zero),
        .Load(c_zero), .Load_Value(c_lv0), .Count_Contents(hi_cnt),
        .Terminal_Count(hi_tc), .Wrap_Pulse(hi_wrap), .Overflow(hi_ovf));

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a step is the count plus or minus one; leaving [0, modulus) is an end-of-range event.
    typedef struct { int cnt; bit wrap; bit ovf; } mstate_t;

    function automatic mstate_t model_step(input mstate_t s, input int modulus, input bit en,
                                           input bit up, input bit sat, input bit load, input int lv);
        mstate_t n;
        int raw;
        n = s;
        n.wrap = 1'b0;
        raw = s.cnt + (up ? 1 : -1);
        if (load) begin
            n.cnt = (lv < modulus) ? lv : modulus - 1;
            n.ovf = 1'b0;
        end else if (en) begin
            if (raw >= 0 && raw < modulus) n.cnt = raw;
            else if (sat) n.ovf = 1'b1;
            else begin
                n.cnt  = (raw + modulus) % modulus;
                n.wrap = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic bit tc_model(input int cnt, input int modulus, input bit en, input bit up, input bit load);
        int raw;
        raw = cnt + (up ? 1 : -1);
        return en && !load && (raw < 0 || raw >= modulus);
    endfunction

    typedef struct { bit en; bit up; bit sat; bit load; logic [3:0] lv; int cnt; bit wrap; bit ovf; bit tc; } vec_t;
    vec_t tbl[15];

    mstate_t ma, md, mb;

    initial begin
        a_clr = 1; a_en = 0; a_up = 0; a_sat = 0; a_load = 0; a_lv = '0;
        b_clr = 1; b_en = 0; b_up = 0; b_sat = 0; b_load = 0; b_lv = '0;
        c_clr = 1; c_en = 0; c_up = 1; c_zero = 0; c_lv0 = '0;

        //            en up sat ld  lv     cnt wr ov tc
        tbl[0]  = '{1, 0, 1, 1, 4'd2,  2, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 4'd0,  1, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 0, 4'd0,  0, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 4'd0,  0, 0, 1, 1};
        tbl[4]  = '{1, 0, 1, 0, 4'd0,  0, 0, 1, 1};
        tbl[5]  = '{0, 0, 1, 0, 4'd0,  0, 0, 1, 0};
        tbl[6]  = '{1, 1, 0, 1, 4'd7,  7, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 1, 4'd15, 9, 0, 0, 0};
        tbl[8]  = '{1, 1, 0, 0, 4'd0,  0, 1, 0, 1};
        tbl[9]  = '{0, 1, 0, 0, 4'd0,  0, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 4'd0,  9, 1, 0, 1};
        tbl[11] = '{1, 1, 1, 0, 4'd0,  9, 0, 1, 1};
        tbl[12] = '{0, 1, 0, 1, 4'd9,  9, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 1, 4'd10, 9, 0, 0, 0};
        tbl[14] = '{1, 1, 0, 1, 4'd0,  0, 0, 0, 0};

        tick();
        check("reset_a_cnt", a_cnt, 3);
        check("reset_a_wrap", a_wrap, 0);
        check("reset_a_ovf", a_ovf, 0);
        check("reset_b_cnt", b_cnt, 0);
        check("reset_d_cnt", d_cnt, 0);
        tick();
        check("reset_hold_a_cnt", a_cnt, 3);
        a_clr = 0; b_clr = 0; c_clr = 0;

        // Table vectors on the MODULUS 10 instance
        for (int i = 0; i < 15; i++) begin
            a_en = tbl[i].en; a_up = tbl[i].up; a_sat = tbl[i].sat;
            a_load = tbl[i].load; a_lv = tbl[i].lv;
            #1;
            check($sformatf("tbl%0d_tc", i), a_tc, tbl[i].tc);
            tick();
            check($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].cnt);
            check($sformatf("tbl%0d_wrap", i), a_wrap, tbl[i].wrap);
            check($sformatf("tbl%0d_ovf", i), a_ovf, tbl[i].ovf);
        end

        // MODULUS 10 counting up with wrap, 12 cycles from 0
        a_load = 0; a_en = 1; a_up = 1; a_sat = 0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            check($sformatf("up10_tc%0d", i), a_tc, ((i - 1) % 10) == 9);
            tick();
            check($sformatf("up10_cnt%0d", i), a_cnt, i % 10);
            check($sformatf("up10_wrap%0d", i), a_wrap, i == 10);
        end
        a_en = 0;

        // Async clear while count is 0x5A with Overflow set
        b_load = 1; b_lv = 8'hFF;
        tick();
        b_load = 0; b_en = 1; b_up = 1; b_sat = 1;
        tick();
        check("b_sat_hold", b_cnt, 255);
        check("b_sat_ovf", b_ovf, 1);
        b_up = 0; b_sat = 0;
        repeat (165) tick();
        check("b_at_5a", b_cnt, 8'h5A);
        check("b_ovf_sticky", b_ovf, 1);
        b_en = 0;
        #3;
        b_clr = 1;
        #1;
        check("clr_async_cnt", b_cnt, 0);
        check("clr_async_ovf", b_ovf, 0);
        check("clr_async_wrap", b_wrap, 0);
        b_en = 1; b_up = 1;
        tick();
        check("clr_held_cnt", b_cnt, 0);
        b_clr = 0;
        #2;
        check("clr_release_nostep", b_cnt, 0);
        tick();
        check("clr_first_step", b_cnt, 1);

        // MODULUS 256 down-wrap from 0, then toggle Up each cycle
        b_clr = 1;
        #1;
        b_clr = 0; b_up = 0; b_sat = 0; b_en = 1;
        #1;
        check("m256_tc_down0", b_tc, 1);
        tick();
        check("m256_cnt_down0", b_cnt, 255);
        check("m256_wrap_down0", b_wrap, 1);
        for (int k = 0; k < 6; k++) begin
            b_up = ~b_up;
            #1;
            check($sformatf("m256_tog_tc%0d", k), b_tc, 1);
            tick();
            check($sformatf("m256_tog_cnt%0d", k), b_cnt, b_up ? 0 : 255);
            check($sformatf("m256_tog_wrap%0d", k), b_wrap, 1);
        end
        b_en = 0;

        // Cascade: low stage terminal count enables the high stage
        c_en = 1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            check($sformatf("casc%0d", i), {hi_cnt, lo_cnt}, i % 256);
        end
        c_en = 0;
        tick();
        check("casc_final", {hi_cnt, lo_cnt}, 8'h2C);

        // Randomized stimulus against the model
        a_clr = 1; b_clr = 1;
        #1;
        a_clr = 0; b_clr = 0;
        ma = '{3, 1'b0, 1'b0};
        md = '{0, 1'b0, 1'b0};
        mb = '{0, 1'b0, 1'b0};
        for (int i = 0; i < 400; i++) begin
            a_en = 1'($urandom_range(0, 3) != 0); a_up = 1'($urandom_range(0, 1));
            a_sat = 1'($urandom_range(0, 1)); a_load = 1'($urandom_range(0, 7) == 0);
            a_lv = 4'($urandom_range(0, 15));
            b_en = 1'($urandom_range(0, 3) != 0); b_up = 1'($urandom_range(0, 1));
            b_sat = 1'($urandom_range(0, 1)); b_load = 1'($urandom_range(0, 7) == 0);
            b_lv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 1) * 255);
            #1;
            check("rnd_a_tc", a_tc, tc_model(ma.cnt, 10, a_en, a_up, a_load));
            check("rnd_d_tc", d_tc, tc_model(md.cnt, 2, a_en, a_up, a_load));
            check("rnd_b_tc", b_tc, tc_model(mb.cnt, 256, b_en, b_up, b_load));
            ma = model_step(ma, 10, a_en, a_up, a_sat, a_load, int'(a_lv));
            md = model_step(md, 2, a_en, a_up, a_sat, a_load, int'(a_lv));
            mb = model_step(mb, 256, b_en, b_up, b_sat, b_load, int'(b_lv));
            tick();
            check("rnd_a_cnt", a_cnt, ma.cnt);
            check("rnd_a_wrap", a_wrap, ma.wrap);
            check("rnd_a_ovf", a_ovf, ma.ovf);
            check("rnd_d_cnt", d_cnt, md.cnt);
            check("rnd_d_wrap", d_wrap, md.wrap);
            check("rnd_d_ovf", d_ovf, md.ovf);
            check("rnd_b_cnt", b_cnt, mb.cnt);
            check("rnd_b_wrap", b_wrap, mb.wrap);
            check("rnd_b_ovf", b_ovf, mb.ovf);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
